// File: rtl/pipeline_pkg.sv
// Shared helpers for the elastic pipeline: width math and stage limits.
package pipeline_pkg;

   // Deepest pipe the design is built for.
   localparam int unsigned MaxStages = 32;

   // Ceiling log2. A value of 0 or 1 gives 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((33'd1 << width) < {1'b0, value}) begin
         width++;
      end
      return width;
   endfunction

   // Width of an occupancy counter that must hold 0..stages. It is never narrower than one bit.
   function automatic int unsigned count_width(input int unsigned stages);
      int unsigned width;
      width = clog2(stages + 1);
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/pipeline_stage.sv
// One elastic stage: a data register, its valid bit and its advance term.
module pipeline_stage #(
   parameter int unsigned      Width   = 16,
   parameter logic [Width-1:0] InitVal = '0
) (
   input  logic             clk_i,
   input  logic             sclr_i,
   input  logic             sinit_i,
   input  logic             ce_i,
   input  logic [Width-1:0] data_i,
   input  logic             valid_i,
   input  logic             adv_next_i,
   output logic [Width-1:0] data_o,
   output logic             valid_o,
   output logic             adv_o
);

   logic [Width-1:0] data_d, data_q;
   logic             valid_d, valid_q;

   // A stage may load when it is empty or when its successor moves on (bubble collapse).
   assign adv_o   = ~valid_q | adv_next_i;
   assign data_o  = data_q;
   assign valid_o = valid_q;

   // Next state: clear > init > hold on CE low > advance. An unknown control poisons the state.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      casez ({sclr_i, sinit_i, ce_i})
         3'b1??: begin
            data_d  = '0;
            valid_d = 1'b0;
         end
         3'b01?: begin
            data_d  = InitVal;
            valid_d = 1'b0;
         end
         3'b001: begin
            if (adv_o) begin
               data_d  = data_i;
               valid_d = valid_i;
            end
         end
         3'b000: begin
            data_d  = data_q;
            valid_d = valid_q;
         end
         default: begin
            data_d  = 'x;
            valid_d = 1'bx;
         end
      endcase
   end

   // State register with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (sclr_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/pipeline_elastic.sv
// Elastic delay line with valid/ready backpressure, flush-to-init and occupancy count.
module pipeline_elastic
   import pipeline_pkg::*;
#(
   parameter int unsigned        C_WIDTH       = 16,
   parameter int unsigned        C_PIPE_STAGES = 2,
   parameter logic [C_WIDTH-1:0] C_SINIT_VAL   = '0,
   parameter int unsigned        C_HAS_CE      = 0,
   parameter int unsigned        C_HAS_SINIT   = 0,
   localparam int unsigned       CountWidth    = count_width(C_PIPE_STAGES)
) (
   input  logic                  CLK,
   input  logic                  SCLR,
   input  logic                  CE,
   input  logic                  SINIT,
   input  logic [C_WIDTH-1:0]    D,
   input  logic                  D_VALID,
   output logic                  D_RDY,
   output logic [C_WIDTH-1:0]    Q,
   output logic                  Q_VALID,
   input  logic                  Q_RDY,
   output logic [CountWidth-1:0] COUNT
);

   localparam int unsigned S = C_PIPE_STAGES;

   logic ce_eff;
   logic sinit_eff;

   // Disabled ports behave as if tied to their inactive level.
   assign ce_eff    = (C_HAS_CE != 0) ? CE : 1'b1;
   assign sinit_eff = (C_HAS_SINIT != 0) ? SINIT : 1'b0;

   if (S > MaxStages) begin : g_bad_depth
      $error("pipeline_elastic: C_PIPE_STAGES exceeds MaxStages");
   end

   if (S == 0) begin : g_bypass
      // Pure wires: no state, so clear and flush have nothing to act on.
      logic unused_bypass;
      assign unused_bypass = ^{CLK, SCLR, sinit_eff};

      assign Q       = D;
      assign Q_VALID = D_VALID;
      assign D_RDY   = Q_RDY & ce_eff;
      assign COUNT   = '0;
   end else begin : g_pipe
      // Index 0 is the input side; index S is the output side.
      logic [S:0][C_WIDTH-1:0] chain_data;
      logic [S:0]              chain_valid;
      logic [S:0]              adv;
      logic                    accept;
      logic                    emit;
      logic [CountWidth-1:0]   count_d, count_q;

      assign chain_data[0]  = D;
      assign chain_valid[0] = D_VALID;
      assign adv[S]         = Q_RDY;

      for (genvar n = 0; n < S; n++) begin : g_stage
         pipeline_stage #(
            .Width   (C_WIDTH),
            .InitVal (C_SINIT_VAL)
         ) u_stage (
            .clk_i      (CLK),
            .sclr_i     (SCLR),
            .sinit_i    (sinit_eff),
            .ce_i       (ce_eff),
            .data_i     (chain_data[n]),
            .valid_i    (chain_valid[n]),
            .adv_next_i (adv[n+1]),
            .data_o     (chain_data[n+1]),
            .valid_o    (chain_valid[n+1]),
            .adv_o      (adv[n])
         );
      end

      assign D_RDY   = ce_eff & ~sinit_eff & ~SCLR & adv[0];
      assign Q       = chain_data[S];
      assign Q_VALID = chain_valid[S];
      assign accept  = D_VALID & D_RDY;
      assign emit    = Q_VALID & Q_RDY;
      assign COUNT   = count_q;

      // Occupancy tracks accepts minus transfers out, with the same priority as the stages.
      always_comb begin
         count_d = count_q;
         casez ({SCLR, sinit_eff, ce_eff})
            3'b1??: count_d = '0;
            3'b01?: count_d = '0;
            3'b001: begin
               unique case ({accept, emit})
                  2'b10:   count_d = count_q + CountWidth'(1);
                  2'b01:   count_d = count_q - CountWidth'(1);
                  default: count_d = count_q;
               endcase
            end
            3'b000:  count_d = count_q;
            default: count_d = 'x;
         endcase
      end

      // Occupancy register with synchronous clear.
      always_ff @(posedge CLK) begin
         if (SCLR) begin
            count_q <= '0;
         end else begin
            count_q <= count_d;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_elastic.sv
// Scoreboard bench for pipeline_elastic: a 3-stage instance plus a bypass instance.
module tb_pipeline_elastic;
   import pipeline_pkg::*;

   localparam int unsigned W   = 16;
   localparam int unsigned S   = 3;
   localparam int unsigned CW  = count_width(S);
   localparam int unsigned CW0 = count_width(0);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 3-stage instance
   logic          sclr, ce, sinit, d_valid, q_rdy;
   logic [W-1:0]  d;
   logic          d_rdy, q_valid;
   logic [W-1:0]  q;
   logic [CW-1:0] count;

   // bypass instance
   logic           sclr0, ce0, sinit0, dv0, qr0;
   logic [W-1:0]   d0;
   logic           d_rdy0, qv0;
   logic [W-1:0]   q0;
   logic [CW0-1:0] count0;

   pipeline_elastic #(
      .C_WIDTH       (W),
      .C_PIPE_STAGES (S),
      .C_SINIT_VAL   (16'hA5A5),
      .C_HAS_CE      (1),
      .C_HAS_SINIT   (1)
   ) dut (
      .CLK     (clk),
      .SCLR    (sclr),
      .CE      (ce),
      .SINIT   (sinit),
      .D       (d),
      .D_VALID (d_valid),
      .D_RDY   (d_rdy),
      .Q       (q),
      .Q_VALID (q_valid),
      .Q_RDY   (q_rdy),
      .COUNT   (count)
   );

   pipeline_elastic #(
      .C_WIDTH       (W),
      .C_PIPE_STAGES (0),
      .C_SINIT_VAL   (16'hA5A5),
      .C_HAS_CE      (1),
      .C_HAS_SINIT   (1)
   ) dut0 (
      .CLK     (clk),
      .SCLR    (sclr0),
      .CE      (ce0),
      .SINIT   (sinit0),
      .D       (d0),
      .D_VALID (dv0),
      .D_RDY   (d_rdy0),
      .Q       (q0),
      .Q_VALID (qv0),
      .Q_RDY   (qr0),
      .COUNT   (count0)
   );

   int unsigned  tests_run    = 0;
   int unsigned  tests_failed = 0;
   bit           mon_en       = 1'b0;
   logic [W-1:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: checks the head word and occupancy, then applies the coming edge to the model.
   always @(negedge clk) begin
      if (mon_en) begin
         check("count_vs_model", 32'(count), sb.size());
         if (q_valid) begin
            if (sb.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL q_valid_unexpected: got q=0x%0h, expected no valid word", q);
            end else begin
               check("q_data", 32'(q), 32'(sb[0]));
            end
         end
         if (sclr || sinit) begin
            sb.delete();
         end else if (ce) begin
            if (q_valid && q_rdy) void'(sb.pop_front());
            if (d_valid && d_rdy) sb.push_back(d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sclr = 1'b1; ce = 1'b1; sinit = 1'b0; d_valid = 1'b0; q_rdy = 1'b0; d = '0;
      sclr0 = 1'b0; ce0 = 1'b1; sinit0 = 1'b0; dv0 = 1'b0; qr0 = 1'b0; d0 = '0;
      step();

      // Reset state
      sclr = 1'b0;
      #1;
      check("rst_q", 32'(q), 32'h0);
      check("rst_q_valid", 32'(q_valid), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_d_rdy", 32'(d_rdy), 32'h1);
      mon_en = 1'b1;

      // Streaming with Q_RDY=1: first word on Q after the third edge, one word per cycle after
      d_valid = 1'b1;
      q_rdy   = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         d = W'(i);
         step();
         if (i == 1) begin
            check("lat_e1_q_valid", 32'(q_valid), 32'h0);
            check("lat_e1_count", 32'(count), 32'h1);
         end
         if (i == 2) begin
            check("lat_e2_q_valid", 32'(q_valid), 32'h0);
            check("lat_e2_count", 32'(count), 32'h2);
         end
         if (i == 3) begin
            check("lat_e3_q", 32'(q), 32'h1);
            check("lat_e3_q_valid", 32'(q_valid), 32'h1);
            check("lat_e3_count", 32'(count), 32'h3);
         end
         if (i == 5) begin
            check("tput_q", 32'(q), 32'h3);
            check("tput_count", 32'(count), 32'h3);
         end
      end
      d_valid = 1'b0;
      repeat (4) step();
      check("stream_drain_count", 32'(count), 32'h0);
      check("stream_drain_q_valid", 32'(q_valid), 32'h0);

      // Fill with Q_RDY=0: pipe reports full and refuses input
      q_rdy   = 1'b0;
      d_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = W'(16'h11 + i);
         step();
      end
      d = 16'h14;
      #1;
      check("full_count", 32'(count), 32'h3);
      check("full_d_rdy", 32'(d_rdy), 32'h0);
      check("full_q", 32'(q), 32'h11);
      step();
      check("full_hold_q", 32'(q), 32'h11);
      check("full_hold_q_valid", 32'(q_valid), 32'h1);
      q_rdy   = 1'b1;
      d_valid = 1'b0;
      repeat (4) step();
      check("full_drain_count", 32'(count), 32'h0);

      // Bubbles collapse behind a stalled output
      q_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d       = W'(16'h21 + i);
         d_valid = (i % 2 == 0);
         step();
      end
      d_valid = 1'b0;
      #1;
      check("bubble_count", 32'(count), 32'h2);
      check("bubble_q_valid", 32'(q_valid), 32'h1);
      check("bubble_q", 32'(q), 32'h21);
      check("bubble_d_rdy", 32'(d_rdy), 32'h1);

      // Flush to init value; the word offered alongside SINIT is not captured
      sinit   = 1'b1;
      d_valid = 1'b1;
      d       = 16'h99;
      #1;
      check("sinit_d_rdy", 32'(d_rdy), 32'h0);
      step();
      sinit   = 1'b0;
      d_valid = 1'b0;
      #1;
      check("sinit_count", 32'(count), 32'h0);
      check("sinit_q_valid", 32'(q_valid), 32'h0);
      check("sinit_q", 32'(q), 32'hA5A5);

      // CE low freezes the pipe mid-stream
      q_rdy   = 1'b1;
      d_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = W'(16'h31 + i);
         step();
      end
      ce = 1'b0;
      d  = 16'h34;
      #1;
      check("ce_d_rdy", 32'(d_rdy), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("ce_hold_q", 32'(q), 32'h31);
         check("ce_hold_q_valid", 32'(q_valid), 32'h1);
         check("ce_hold_count", 32'(count), 32'h3);
         check("ce_hold_d_rdy", 32'(d_rdy), 32'h0);
      end
      ce = 1'b1;
      step();
      check("ce_resume_q", 32'(q), 32'h32);
      d_valid = 1'b0;
      repeat (5) step();
      check("ce_drain_count", 32'(count), 32'h0);
      check("ce_drain_q_valid", 32'(q_valid), 32'h0);
      check("sb_drained", sb.size(), 32'h0);

      // Zero-stage bypass
      d0  = 16'h1234;
      dv0 = 1'b1;
      qr0 = 1'b1;
      #1;
      check("byp_q", 32'(q0), 32'h1234);
      check("byp_q_valid", 32'(qv0), 32'h1);
      check("byp_d_rdy_hi", 32'(d_rdy0), 32'h1);
      check("byp_count", 32'(count0), 32'h0);
      qr0 = 1'b0;
      #1;
      check("byp_d_rdy_lo", 32'(d_rdy0), 32'h0);
      qr0 = 1'b1;
      ce0 = 1'b0;
      #1;
      check("byp_d_rdy_ce", 32'(d_rdy0), 32'h0);
      dv0 = 1'b0;
      #1;
      check("byp_q_valid_lo", 32'(qv0), 32'h0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
